// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS-style control unit: sequences FETCH/DECODE/EXEC/MEM/WB and owns the PC and IR.
// Latency: 3 cycles for branch/J, 4 for R/I-type and SW, 5 for LW; +1 per wait cycle on either handshake.
// Backpressure: instr_req_o / mem_req_o are held until their ready arrives; a ready with no request is ignored.
//
// Ports:
//   clk_i, rst_n_i                 clock, async active-low reset
//   instr_req_o/instr_ready_i/instr_i   fetch handshake (address = pc_o)
//   alu_zero_i                     ALU result == 0, used for BEQ/BNE
//   mem_req_o/mem_we_o/mem_ready_i data memory handshake (mem_we_o: 1 = store)
//   pc_o, ir_o, imm_ext_o          PC, instruction register, extended immediate
//   alu_src_o, reg_dest_o, mem_to_reg_o  decoded datapath controls (held DECODE..next DECODE)
//   reg_write_o, illegal_o         one-cycle strobes
//   state_o                        FSM state (FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4)
module multicycle_control_unit #(
    parameter int              DATA_W   = 32,
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    output logic              instr_req_o,
    input  logic              instr_ready_i,
    input  logic [31:0]       instr_i,
    input  logic              alu_zero_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    input  logic              mem_ready_i,
    output logic [PC_W-1:0]   pc_o,
    output logic [31:0]       ir_o,
    output logic [DATA_W-1:0] imm_ext_o,
    output logic              alu_src_o,
    output logic              reg_dest_o,
    output logic              mem_to_reg_o,
    output logic              reg_write_o,
    output logic              illegal_o,
    output logic [2:0]        state_o
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    state_t          state_q, state_d;
    logic            running_q;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [31:0]     ir_q;
    logic            alu_src_q, reg_dest_q, mem_to_reg_q;
    logic            pc_load, ir_load, ctl_load;

    logic [5:0]      opcode;
    logic            dec_legal, dec_alu_src, dec_reg_dest, dec_mem_to_reg;
    logic            zext;
    logic [PC_W-1:0] br_off;
    logic [PC_W-1:0] jmp_tgt;

    assign opcode = ir_q[31:26];
    assign zext   = (opcode == OP_ANDI) || (opcode == OP_ORI);

    assign imm_ext_o = zext ? DATA_W'(ir_q[15:0]) : DATA_W'($signed(ir_q[15:0]));

    // Offset is sign-extended to full PC width first, then scaled to bytes.
    assign br_off = PC_W'($signed(ir_q[15:0])) << 2;

    // Jump keeps the top PC bits of PC+4 (pc_q already holds PC+4 in EXEC).
    if (PC_W > 28) begin : g_jmp_hi
        assign jmp_tgt = {pc_q[PC_W-1:28], ir_q[25:0], 2'b00};
    end else begin : g_jmp_full
        assign jmp_tgt = {ir_q[25:0], 2'b00};
    end

    always_comb begin
        dec_legal      = 1'b1;
        dec_alu_src    = 1'b0;
        dec_reg_dest   = 1'b0;
        dec_mem_to_reg = 1'b0;
        case (opcode)
            OP_RTYPE:                              dec_reg_dest = 1'b1;
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_SW: dec_alu_src = 1'b1;
            OP_LW: begin
                dec_alu_src    = 1'b1;
                dec_mem_to_reg = 1'b1;
            end
            OP_BEQ, OP_BNE, OP_J: begin
                dec_legal = 1'b1;
            end
            default:                               dec_legal = 1'b0;
        endcase
    end

    // running_q keeps the fetch request low while reset is asserted and
    // releases it on the first clock after reset goes away.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= S_FETCH;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            running_q <= 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pc_load     = 1'b0;
        ir_load     = 1'b0;
        ctl_load    = 1'b0;
        instr_req_o = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        reg_write_o = 1'b0;
        illegal_o   = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (running_q) begin
                    instr_req_o = 1'b1;
                    if (instr_ready_i) begin
                        ir_load = 1'b1;
                        pc_load = 1'b1;
                        pc_d    = pc_q + PC_W'(4);
                        state_d = S_DECODE;
                    end
                end
            end
            S_DECODE: begin
                // Illegal opcodes load all-zero controls and retire as a NOP.
                ctl_load = 1'b1;
                if (dec_legal) begin
                    state_d = S_EXEC;
                end else begin
                    illegal_o = 1'b1;
                    state_d   = S_FETCH;
                end
            end
            S_EXEC: begin
                case (opcode)
                    OP_BEQ, OP_BNE: begin
                        if ((opcode == OP_BEQ) == alu_zero_i) begin
                            pc_load = 1'b1;
                            pc_d    = pc_q + br_off;
                        end
                        state_d = S_FETCH;
                    end
                    OP_J: begin
                        pc_load = 1'b1;
                        pc_d    = jmp_tgt;
                        state_d = S_FETCH;
                    end
                    OP_LW, OP_SW: state_d = S_MEM;
                    default:      state_d = S_WB;
                endcase
            end
            S_MEM: begin
                mem_req_o = 1'b1;
                mem_we_o  = (opcode == OP_SW);
                if (mem_ready_i) begin
                    state_d = (opcode == OP_SW) ? S_FETCH : S_WB;
                end
            end
            S_WB: begin
                reg_write_o = 1'b1;
                state_d     = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pc_q         <= RESET_PC;
            ir_q         <= '0;
            alu_src_q    <= 1'b0;
            reg_dest_q   <= 1'b0;
            mem_to_reg_q <= 1'b0;
        end else begin
            if (pc_load) pc_q <= pc_d;
            if (ir_load) ir_q <= instr_i;
            if (ctl_load) begin
                alu_src_q    <= dec_alu_src;
                reg_dest_q   <= dec_reg_dest;
                mem_to_reg_q <= dec_mem_to_reg;
            end
        end
    end

    assign pc_o         = pc_q;
    assign ir_o         = ir_q;
    assign alu_src_o    = alu_src_q;
    assign reg_dest_o   = reg_dest_q;
    assign mem_to_reg_o = mem_to_reg_q;
    assign state_o      = state_q;

endmodule
